// File: rtl/gpio_bus_master.sv
// Bus initiator: for one multiply job, writes A1/A2/start, polls status, reads W and L.
// Optional poll timeout is compiled in when GPIO_BUS_MASTER_TIMEOUT_EN is defined.
module gpio_bus_master #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned POLL_GAP      = 4,
    parameter int unsigned POLL_MAX      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_l,
    output logic        rsp_ovf,
    output logic        rsp_timeout,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid-side
    // data stays stable until then, and ready/valid here are registered (no input-to-output path).

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("STROBE_CYCLES must be 1..15");
    end
    if (POLL_GAP > 255) begin : g_bad_gap
        $error("POLL_GAP must be 0..255");
    end
    if (POLL_MAX < 1 || POLL_MAX > 65535) begin : g_bad_poll_max
        $error("POLL_MAX must be 1..65535");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_RD_STAT, S_GAP, S_RD_W, S_RD_L, S_RESP
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    localparam logic [15:0] ADDR_A1   = 16'h0380;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;
    localparam logic [3:0]  STROBE_LAST = 4'(STROBE_CYCLES);
    localparam logic [7:0]  GAP_LAST    = 8'(POLL_GAP - 1);

    state_t      state;
    phase_t      phase;
    logic [3:0]  strobe_cnt;
    logic [7:0]  gap_cnt;
    logic [23:0] a2_q;
    logic        stat_done;
    logic        poll_expired;
    logic        is_read;

    assign is_read = (state == S_RD_STAT) || (state == S_RD_W) || (state == S_RD_L);

`ifdef GPIO_BUS_MASTER_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic [15:0] poll_inc;

    // Saturating count of status reads in the current job.
    assign poll_inc     = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
    assign poll_expired = (32'(poll_inc) >= 32'(POLL_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (state == S_IDLE && cmd_ready && cmd_valid) begin
            poll_cnt <= '0;
        end else if (state == S_RD_STAT && phase == PH_HOLD) begin
            poll_cnt <= poll_inc;
        end
    end
`else
    assign poll_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            phase       <= PH_SETUP;
            strobe_cnt  <= '0;
            gap_cnt     <= '0;
            a2_q        <= '0;
            stat_done   <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_w       <= '0;
            rsp_l       <= '0;
            rsp_ovf     <= 1'b0;
            rsp_timeout <= 1'b0;
            saddress    <= '0;
            swr         <= 1'b0;
            srd         <= 1'b0;
            sdata_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready   <= 1'b0;
                        a2_q        <= cmd_a2;
                        rsp_w       <= '0;
                        rsp_l       <= '0;
                        rsp_ovf     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        saddress    <= ADDR_A1;
                        sdata_out   <= {8'd0, cmd_a1};
                        phase       <= PH_SETUP;
                        state       <= S_WR_A1;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt  <= '0;
                        saddress <= ADDR_CTRL;
                        phase    <= PH_SETUP;
                        state    <= S_RD_STAT;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            phase      <= PH_STROBE;
                            strobe_cnt <= 4'd1;
                            if (is_read) srd <= 1'b1;
                            else         swr <= 1'b1;
                        end
                        PH_STROBE: begin
                            if (strobe_cnt == STROBE_LAST) begin
                                srd        <= 1'b0;
                                swr        <= 1'b0;
                                strobe_cnt <= '0;
                                phase      <= PH_HOLD;
                                // Read data is taken on the edge that ends the strobe.
                                case (state)
                                    S_RD_STAT: begin
                                        stat_done <= sdata_in[1];
                                        rsp_ovf   <= ~sdata_in[0];
                                    end
                                    S_RD_W:  rsp_w <= sdata_in;
                                    S_RD_L:  rsp_l <= sdata_in[23:0];
                                    default: ;
                                endcase
                            end else begin
                                strobe_cnt <= strobe_cnt + 4'd1;
                            end
                        end
                        default: begin
                            phase     <= PH_SETUP;
                            sdata_out <= '0;
                            saddress  <= '0;
                            case (state)
                                S_WR_A1: begin
                                    saddress  <= ADDR_A2;
                                    sdata_out <= {8'd0, a2_q};
                                    state     <= S_WR_A2;
                                end
                                S_WR_A2: begin
                                    saddress <= ADDR_CTRL;
                                    state    <= S_WR_GO;
                                end
                                S_WR_GO: begin
                                    saddress <= ADDR_CTRL;
                                    state    <= S_RD_STAT;
                                end
                                S_RD_STAT: begin
                                    if (stat_done) begin
                                        saddress <= ADDR_W;
                                        state    <= S_RD_W;
                                    end else if (poll_expired) begin
                                        rsp_ovf     <= 1'b0;
                                        rsp_timeout <= 1'b1;
                                        rsp_valid   <= 1'b1;
                                        state       <= S_RESP;
                                    end else if (POLL_GAP == 0) begin
                                        saddress <= ADDR_CTRL;
                                        state    <= S_RD_STAT;
                                    end else begin
                                        gap_cnt <= '0;
                                        state   <= S_GAP;
                                    end
                                end
                                S_RD_W: begin
                                    saddress <= ADDR_L;
                                    state    <= S_RD_L;
                                end
                                default: begin
                                    rsp_valid <= 1'b1;
                                    state     <= S_RESP;
                                end
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master: responder model, bus-op and response scoreboards, directed + random jobs.
module tb_gpio_bus_master;

    localparam int S   = 2;
    localparam int G   = 4;
    localparam int PM  = 4;
    localparam int ACC = S + 2;
    localparam logic [15:0] STAT = 16'h03A0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_a1 = '0;
    logic [23:0] cmd_a2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic        rsp_ovf;
    logic        rsp_timeout;
    logic [15:0] saddress;
    logic        swr;
    logic        srd;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_bus_master #(.STROBE_CYCLES(S), .POLL_GAP(G), .POLL_MAX(PM)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a1(cmd_a1), .cmd_a2(cmd_a2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_w(rsp_w), .rsp_l(rsp_l),
        .rsp_ovf(rsp_ovf), .rsp_timeout(rsp_timeout),
        .saddress(saddress), .swr(swr), .srd(srd), .sdata_out(sdata_out), .sdata_in(sdata_in)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [57:0] exp_q[$];
    int          lat_q[$];
    logic [48:0] bus_q[$];
    logic        job_start = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder model: multiplies the written operands, done after r_done_after status reads.
    logic [31:0] r_a1 = '0;
    logic [31:0] r_a2 = '0;
    logic [31:0] r_l = '0;
    int          r_stat = 0;
    int          r_done_after = 1;
    logic        srd_q = 1'b0;
    logic        swr_q = 1'b0;
    logic [63:0] r_prod;

    assign r_prod = {32'd0, r_a1} * {32'd0, r_a2};

    always @(posedge clk) begin
        srd_q <= srd;
        swr_q <= swr;
        if (swr && !swr_q) begin
            case (saddress)
                16'h0380: r_a1 <= sdata_out;
                16'h0388: r_a2 <= sdata_out;
                16'h03A0: r_stat <= 0;
                default: ;
            endcase
        end
        if (srd_q && !srd && saddress == STAT) r_stat <= r_stat + 1;
    end

    always_comb begin
        sdata_in = 32'd0;
        case (saddress)
            16'h03A0: sdata_in = {30'd0, 1'(r_stat + 1 >= r_done_after), 1'(r_prod[63:32] == 32'd0)};
            16'h0390: sdata_in = r_prod[31:0];
            16'h0398: sdata_in = r_l;
            default: ;
        endcase
    end

    task automatic send_job(input logic [23:0] a1, input logic [23:0] a2, input int n,
                            input logic [31:0] l);
        logic [63:0] p;
        bit          to;
        int          reads;
        int          k;
        int          w;
        to    = 1'b0;
        reads = n;
`ifdef GPIO_BUS_MASTER_TIMEOUT_EN
        if (n > PM) begin
            to    = 1'b1;
            reads = PM;
        end
`endif
        r_done_after = n;
        r_l          = l;
        @(negedge clk);
        cmd_a1    = a1;
        cmd_a2    = a2;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("cmd_accept", cmd_ready, 1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        k = cyc + 1;
        p = {40'd0, a1} * {40'd0, a2};
        bus_q.push_back({1'b1, 16'h0380, 8'd0, a1});
        bus_q.push_back({1'b1, 16'h0388, 8'd0, a2});
        bus_q.push_back({1'b1, 16'h03A0, 32'd0});
        for (int i = 0; i < reads; i++) bus_q.push_back({1'b0, STAT, 32'd0});
        if (to) begin
            exp_q.push_back({1'b1, 1'b0, 24'd0, 32'd0});
            lat_q.push_back(k + (3 + reads) * ACC + (reads - 1) * G);
        end else begin
            bus_q.push_back({1'b0, 16'h0390, 32'd0});
            bus_q.push_back({1'b0, 16'h0398, 32'd0});
            exp_q.push_back({1'b0, 1'(p[63:32] != 0), l[23:0], p[31:0]});
            lat_q.push_back(k + (5 + reads) * ACC + (reads - 1) * G);
        end
        job_start = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 3000) begin
            @(negedge clk);
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
            n++;
        end
        rsp_ready = 1'b1;
        check("job_complete", {exp_q.size() != 0, rsp_valid}, 0);
    endtask

    // Bus monitor: access shape, spacing and op sequence against bus_q.
    logic        bm_in = 1'b0;
    int          bm_len = 0;
    logic [15:0] bm_addr = '0;
    logic [15:0] prev_addr = '0;
    int          prev_start = 0;
    logic        prev_stat = 1'b0;
    logic [48:0] bm_op;

    always @(negedge clk) begin
        if (reset) begin
            bm_in  = 1'b0;
            bm_len = 0;
        end else begin
            check("srd_swr_overlap", srd && swr, 0);
            if ((srd || swr) && !bm_in) begin
                check("setup_addr", saddress, prev_addr);
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", bus_q.size(), 1);
                end else begin
                    bm_op = bus_q.pop_front();
                    check("bus_dir", swr, bm_op[48]);
                    check("bus_addr", saddress, bm_op[47:32]);
                    if (bm_op[48]) check("bus_wdata", sdata_out, bm_op[31:0]);
                end
                if (!job_start)
                    check("access_spacing", cyc - prev_start,
                          ACC + ((prev_stat && srd && saddress == STAT) ? G : 0));
                job_start  = 1'b0;
                prev_start = cyc;
                prev_stat  = srd && saddress == STAT;
                bm_in      = 1'b1;
                bm_len     = 1;
                bm_addr    = saddress;
            end else if ((srd || swr) && bm_in) begin
                bm_len++;
                check("strobe_addr_hold", saddress, bm_addr);
            end else if (bm_in) begin
                check("strobe_len", bm_len, S);
                check("hold_addr", saddress, bm_addr);
                bm_in = 1'b0;
            end
            prev_addr = saddress;
        end
    end

    // Response monitor: pops expected result and rise time on each new rsp_valid.
    logic        rv_q = 1'b0;
    logic [57:0] rm_exp;
    int          rm_lat;

    always @(negedge clk) begin
        if (reset) begin
            rv_q = 1'b0;
        end else begin
            check("valid_ready_excl", rsp_valid && cmd_ready, 0);
            if (rsp_valid && !rv_q) begin
                if (exp_q.size() == 0 || lat_q.size() == 0) begin
                    check("rsp_unexpected", exp_q.size(), 1);
                end else begin
                    rm_exp = exp_q.pop_front();
                    rm_lat = lat_q.pop_front();
                    check("rsp_w", rsp_w, rm_exp[31:0]);
                    check("rsp_l", rsp_l, rm_exp[55:32]);
                    check("rsp_ovf", rsp_ovf, rm_exp[56]);
                    check("rsp_timeout", rsp_timeout, rm_exp[57]);
                    check("rsp_latency", cyc, rm_lat);
                end
            end
            rv_q = rsp_valid;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got no end expected end by cycle 60000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        logic [23:0] a1;
        logic [23:0] a2;
        logic [57:0] snap;
        int          w;
        bit          seen;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_bus", {saddress, swr, srd, sdata_out}, 0);
        check("rst_rsp", {rsp_valid, rsp_w, rsp_l, rsp_ovf, rsp_timeout}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);

        send_job(24'd3, 24'd5, 1, 32'd2);
        wait_done(1'b0);
        send_job(24'hFFFFFF, 24'hFFFFFF, 1, 32'd8);
        wait_done(1'b0);
        send_job(24'h001234, 24'h000056, 3, 32'hABCDEF12);
        wait_done(1'b0);

        for (int i = 0; i < 12; i++) begin
            a1 = 24'($urandom);
            a2 = 24'($urandom);
            if ($urandom_range(0, 1) == 1) a1 = 24'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) a2 = 24'($urandom_range(0, 255));
            send_job(a1, a2, $urandom_range(1, 4), $urandom);
            wait_done(1'b1);
        end

        // Held response with a stray command that must be ignored.
        rsp_ready = 1'b0;
        send_job(24'h00ABCD, 24'h000123, 2, 32'h00FF00FF);
        @(negedge clk);
        cmd_a1    = 24'h111111;
        cmd_a2    = 24'h222222;
        cmd_valid = 1'b1;
        w = 0;
        while (!rsp_valid && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("hold_rsp_seen", rsp_valid, 1);
        snap = {rsp_timeout, rsp_ovf, rsp_l, rsp_w};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_stable", {rsp_timeout, rsp_ovf, rsp_l, rsp_w}, snap);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_hs", cmd_ready, 1);
        check("rsp_valid_after_hs", rsp_valid, 0);
        wait_done(1'b0);

`ifdef GPIO_BUS_MASTER_TIMEOUT_EN
        send_job(24'h000007, 24'h000009, 100000, 32'h12345678);
        wait_done(1'b0);
`endif

        // Reset in the middle of the W read.
        send_job(24'h0F0F0F, 24'h000321, 1, 32'h005A5A5A);
        w = 0;
        while (!(srd && saddress == 16'h0390) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("reach_rd_w", {srd, saddress}, {1'b1, 16'h0390});
        reset = 1'b1;
        #1;
        check("midrst_srd", srd, 0);
        check("midrst_bus", {saddress, swr, srd, sdata_out}, 0);
        check("midrst_rsp", {rsp_valid, rsp_w, rsp_l, rsp_ovf, rsp_timeout}, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        exp_q.delete();
        lat_q.delete();
        bus_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_midrst", cmd_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_midrst", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
